// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD screen sequencer.
//   - lcd_state_e : sequencer states
//   - RS/RW encodings, DDRAM-set opcode and row-base constants
//   - helpers that build the 10-bit {RS,RW,DB[7:0]} instruction word
package lcd_pkg;

  typedef enum logic [2:0] {
    S_WAIT_INIT,
    S_SET_ROW,
    S_FETCH,
    S_WRITE,
    S_BLINK_WAIT,
    S_CUR_SET,
    S_CUR_FETCH,
    S_CUR_WRITE
  } lcd_state_e;

  localparam logic       RS_CMD    = 1'b0;
  localparam logic       RS_DATA   = 1'b1;
  localparam logic       RW_WRITE  = 1'b0;
  localparam logic [7:0] DDRAM_SET = 8'h80;
  localparam logic [7:0] ROW0_BASE = 8'h00;
  localparam logic [7:0] ROW1_BASE = 8'h40;

  // Set-DDRAM-address command for a 7-bit display address.
  function automatic logic [9:0] ddram_instr(input logic [6:0] addr);
    return {RS_CMD, RW_WRITE, DDRAM_SET | {1'b0, addr}};
  endfunction

  // Data-write command for one glyph.
  function automatic logic [9:0] data_instr(input logic [7:0] ch);
    return {RS_DATA, RW_WRITE, ch};
  endfunction

endpackage

// File: rtl/lcd_blink_timer.sv
// Blink half-period timer.
//   clk, reset   : clock, async active-low reset
//   clr_i        : zero the counter and force the phase to OFF
//   run_i        : counter advances this cycle
//   wrap_en_i    : a terminal count may wrap (otherwise it holds there)
//   tick_o       : terminal count reached and wrapping this cycle
//   phase_o      : 1 = cursor-on phase, 0 = cursor-off phase
module lcd_blink_timer #(
  parameter int BLINK_CYCLES = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic run_i,
  input  logic wrap_en_i,
  output logic tick_o,
  output logic phase_o
);

  localparam int            CW   = $clog2(BLINK_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(BLINK_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic          phase_q;

  assign tick_o  = run_i && wrap_en_i && (cnt_q == LAST);
  assign phase_o = phase_q;

  // The counter saturates at LAST when wrapping is blocked (e.g. a redraw
  // is pending), so it never runs past one half-period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (run_i) begin
      if (cnt_q == LAST) begin
        if (wrap_en_i) begin
          cnt_q   <= '0;
          phase_q <= ~phase_q;
        end
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/lcd_screen_fsm.sv
// Character-LCD screen sequencer.
// Waits for LCD init, draws ROWS x COLS characters from the character memory,
// then blinks a cursor and redraws the whole screen on refresh requests.
//   clk, reset        : clock, async active-low reset
//   init_done         : LCD power-on init complete
//   instr_fsm_done    : one-cycle completion pulse from the instruction FSM
//   char_data         : character memory data (1 cycle after char_addr)
//   refresh_req       : one-cycle redraw request
//   blink_en          : 1 = blink cursor, 0 = show memory char at cursor
//   cursor_row/col    : cursor position, sampled at each blink tick
//   instr_fsm_enable  : instruction request (held until done)
//   instruction       : {RS,RW,DB[7:0]}
//   char_addr         : character memory address
//   busy              : drawing (not idle in WAIT_INIT / BLINK_WAIT)
module lcd_screen_fsm
  import lcd_pkg::*;
#(
  parameter int         COLS         = 16,
  parameter int         ROWS         = 2,
  parameter int         ADDR_W       = 11,
  parameter int         BLINK_CYCLES = 50000000,
  parameter logic [7:0] CURSOR_CHAR  = 8'hFF,
  parameter logic [7:0] BLANK_CHAR   = 8'h20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_done,
  input  logic              instr_fsm_done,
  input  logic [7:0]        char_data,
  input  logic              refresh_req,
  input  logic              blink_en,
  input  logic [1:0]        cursor_row,
  input  logic [5:0]        cursor_col,
  output logic              instr_fsm_enable,
  output logic [9:0]        instruction,
  output logic [ADDR_W-1:0] char_addr,
  output logic              busy
);

  localparam logic [5:0]  COL_LAST = 6'(COLS - 1);
  localparam logic [1:0]  ROW_LAST = 2'(ROWS - 1);
  localparam logic [6:0]  COLS7    = 7'(COLS);
  localparam logic [31:0] COLS_U   = 32'(COLS);

  lcd_state_e        state_q, state_d;
  logic [1:0]        row_q, row_d, cur_row_q, cur_row_d;
  logic [5:0]        col_q, col_d, cur_col_q, cur_col_d;
  logic              en_q, en_d, busy_q, busy_d, pend_q, pend_d;
  logic              use_mem_q, use_mem_d;
  logic [9:0]        instr_q, instr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              tmr_clr, tmr_run, tmr_wrap_en, tick, phase;

  function automatic logic [6:0] row_base(input logic [1:0] r);
    case (r)
      2'd0:    return ROW0_BASE[6:0];
      2'd1:    return ROW1_BASE[6:0];
      2'd2:    return COLS7;
      default: return ROW1_BASE[6:0] + COLS7;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input logic [1:0] r, input logic [5:0] c);
    logic [31:0] lin;
    lin = {30'd0, r} * COLS_U + {26'd0, c};
    return lin[ADDR_W-1:0];
  endfunction

  // The timer keeps running through the cursor update so the blink period
  // is independent of instruction-FSM latency; a pending redraw blocks the wrap.
  assign tmr_run     = (state_q == S_BLINK_WAIT) || (state_q == S_CUR_SET) ||
                       (state_q == S_CUR_FETCH)  || (state_q == S_CUR_WRITE);
  assign tmr_wrap_en = (state_q == S_BLINK_WAIT) && !pend_q;

  lcd_blink_timer #(.BLINK_CYCLES(BLINK_CYCLES)) u_blink (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (tmr_clr),
    .run_i     (tmr_run),
    .wrap_en_i (tmr_wrap_en),
    .tick_o    (tick),
    .phase_o   (phase)
  );

  // Issue states share one pattern: raise enable with the instruction in the
  // first cycle (enable always enters low), then leave on the done pulse.
  // Done while enable is low falls into the raise branch and is ignored.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    en_d      = en_q;
    instr_d   = instr_q;
    addr_d    = addr_q;
    use_mem_d = use_mem_q;
    tmr_clr   = 1'b0;
    case (state_q)
      S_WAIT_INIT: if (init_done) begin
        state_d = S_SET_ROW;
        row_d   = 2'd0;
        col_d   = 6'd0;
      end
      S_SET_ROW: begin
        if (!en_q) begin
          en_d    = 1'b1;
          instr_d = ddram_instr(row_base(row_q));
        end else if (instr_fsm_done) begin
          en_d    = 1'b0;
          state_d = S_FETCH;
          addr_d  = addr_of(row_q, col_q);
        end
      end
      S_FETCH: state_d = S_WRITE;
      S_WRITE: begin
        if (!en_q) begin
          en_d    = 1'b1;
          instr_d = data_instr(char_data);
        end else if (instr_fsm_done) begin
          en_d = 1'b0;
          if (col_q < COL_LAST) begin
            col_d   = col_q + 6'd1;
            addr_d  = addr_of(row_q, col_q + 6'd1);
            state_d = S_FETCH;
          end else begin
            col_d = 6'd0;
            if (row_q < ROW_LAST) begin
              row_d   = row_q + 2'd1;
              state_d = S_SET_ROW;
            end else begin
              row_d   = 2'd0;
              tmr_clr = 1'b1;
              state_d = S_BLINK_WAIT;
            end
          end
        end
      end
      S_BLINK_WAIT: begin
        if (pend_q) begin
          state_d = S_SET_ROW;
          row_d   = 2'd0;
          col_d   = 6'd0;
        end else if (tick) begin
          cur_row_d = (cursor_row > ROW_LAST) ? ROW_LAST : cursor_row;
          cur_col_d = (cursor_col > COL_LAST) ? COL_LAST : cursor_col;
          state_d   = S_CUR_SET;
        end
      end
      S_CUR_SET: begin
        if (!en_q) begin
          en_d    = 1'b1;
          instr_d = ddram_instr(row_base(cur_row_q) + {1'b0, cur_col_q});
        end else if (instr_fsm_done) begin
          en_d      = 1'b0;
          use_mem_d = !blink_en;
          if (blink_en) begin
            state_d = S_CUR_WRITE;
          end else begin
            addr_d  = addr_of(cur_row_q, cur_col_q);
            state_d = S_CUR_FETCH;
          end
        end
      end
      S_CUR_FETCH: state_d = S_CUR_WRITE;
      S_CUR_WRITE: begin
        if (!en_q) begin
          en_d    = 1'b1;
          instr_d = data_instr(use_mem_q ? char_data : (phase ? CURSOR_CHAR : BLANK_CHAR));
        end else if (instr_fsm_done) begin
          en_d    = 1'b0;
          state_d = S_BLINK_WAIT;
        end
      end
      default: state_d = S_WAIT_INIT;
    endcase

    // Pending redraw is consumed when a full redraw starts (row 0 SET_ROW);
    // a new request in that same cycle wins and schedules another redraw.
    pend_d = pend_q;
    if (state_d == S_SET_ROW && state_q != S_SET_ROW && row_d == 2'd0) pend_d = 1'b0;
    if (refresh_req) pend_d = 1'b1;

    busy_d = !(state_d == S_WAIT_INIT || state_d == S_BLINK_WAIT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_WAIT_INIT;
      row_q     <= '0;
      col_q     <= '0;
      cur_row_q <= '0;
      cur_col_q <= '0;
      en_q      <= 1'b0;
      instr_q   <= '0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      pend_q    <= 1'b0;
      use_mem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      cur_row_q <= cur_row_d;
      cur_col_q <= cur_col_d;
      en_q      <= en_d;
      instr_q   <= instr_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      pend_q    <= pend_d;
      use_mem_q <= use_mem_d;
    end
  end

  assign instr_fsm_enable = en_q;
  assign instruction      = instr_q;
  assign char_addr        = addr_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_lcd_screen_fsm.sv
// Scoreboard bench: instance A (2x16, 20-cycle blink) exercises draw, blink,
// refresh and reset; instance B (4x20) exercises the 4-row address map.
module tb_lcd_screen_fsm;

  localparam int LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, reset_b, init_done, refresh_req, blink_en;
  logic [1:0] cursor_row;
  logic [5:0] cursor_col;

  logic a_done, a_en, a_busy;
  logic [9:0] a_instr;
  logic [10:0] a_addr;
  logic [7:0] a_data = 8'h00;

  logic b_done, b_en, b_busy;
  logic [9:0] b_instr;
  logic [10:0] b_addr;
  logic [7:0] b_data = 8'h00;

  lcd_screen_fsm #(.COLS(16), .ROWS(2), .ADDR_W(11), .BLINK_CYCLES(20),
                   .CURSOR_CHAR(8'hFF), .BLANK_CHAR(8'h20)) dut_a (
    .clk(clk), .reset(reset), .init_done(init_done), .instr_fsm_done(a_done),
    .char_data(a_data), .refresh_req(refresh_req), .blink_en(blink_en),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .instr_fsm_enable(a_en),
    .instruction(a_instr), .char_addr(a_addr), .busy(a_busy));

  lcd_screen_fsm #(.COLS(20), .ROWS(4), .ADDR_W(11), .BLINK_CYCLES(5000),
                   .CURSOR_CHAR(8'hFF), .BLANK_CHAR(8'h20)) dut_b (
    .clk(clk), .reset(reset_b), .init_done(init_done), .instr_fsm_done(b_done),
    .char_data(b_data), .refresh_req(1'b0), .blink_en(blink_en),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .instr_fsm_enable(b_en),
    .instruction(b_instr), .char_addr(b_addr), .busy(b_busy));

  int checks = 0, fails = 0, cyc = 0, a_dones = 0, b_dones = 0;
  logic [9:0] qa[$];
  logic [9:0] qb[$];

  // Memory content: char at address a is a+0x22, so address 31 holds 'A'.
  function automatic logic [7:0] mem_f(input int a);
    return 8'(a + 34);
  endfunction

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    a_data <= mem_f(int'(a_addr));
    b_data <= mem_f(int'(b_addr));
  end

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] set_i(input int r, input int cols);
    int base;
    base = (r == 0) ? 0 : (r == 1) ? 'h40 : (r == 2) ? cols : 'h40 + cols;
    return 10'('h80 + base);
  endfunction

  task automatic push(input bit to_b, input logic [9:0] v);
    if (to_b) qb.push_back(v); else qa.push_back(v);
  endtask

  task automatic push_draw(input bit to_b, input int rows, input int cols);
    for (int r = 0; r < rows; r++) begin
      push(to_b, set_i(r, cols));
      for (int c = 0; c < cols; c++) push(to_b, {2'b10, mem_f(r * cols + c)});
    end
  endtask

  task automatic wait_q(input bit b, input int lim, input int maxc, input string nm);
    int n = 0;
    while ((b ? qb.size() : qa.size()) > lim && n < maxc) begin
      @(posedge clk); #1; n++;
    end
    chk((b ? qb.size() : qa.size()) <= lim, nm, b ? qb.size() : qa.size(), lim);
  endtask

  // Busy must drop exactly on the edge that consumes the last done pulse.
  task automatic wait_busy(input bit b, input int exp, input string nm);
    int n = 0;
    while (!(b ? b_busy : a_busy) && n < 200) begin @(posedge clk); #1; n++; end
    while ((b ? b_busy : a_busy) && n < 1500) begin @(posedge clk); #1; n++; end
    chk(!(b ? b_busy : a_busy) && (b ? b_dones : a_dones) == exp, nm,
        b ? b_dones : a_dones, exp);
  endtask

  task automatic pulse_refresh();
    refresh_req = 1'b1;
    @(posedge clk); #1;
    refresh_req = 1'b0;
  endtask

  // Instruction-FSM models: done LAT cycles after enable seen high.
  initial begin
    a_done = 1'b0;
    forever begin
      @(negedge clk);
      if (a_en) begin
        repeat (LAT - 1) @(negedge clk);
        if (a_en) begin
          a_done = 1'b1; a_dones++;
          @(negedge clk);
          a_done = 1'b0;
        end
      end
    end
  end

  initial begin
    b_done = 1'b0;
    forever begin
      @(negedge clk);
      if (b_en) begin
        repeat (LAT - 1) @(negedge clk);
        if (b_en) begin
          b_done = 1'b1; b_dones++;
          @(negedge clk);
          b_done = 1'b0;
        end
      end
    end
  end

  // Monitors: pop one expectation per enable rise; instruction held stable.
  initial begin
    logic pa;
    logic [9:0] ha, e;
    int last_cs;
    pa = 1'b0; ha = '0; last_cs = -1;
    forever begin
      @(negedge clk);
      if (a_en && !pa) begin
        chk(qa.size() > 0, "a_expected_pending", qa.size(), 1);
        if (qa.size() > 0) begin
          e = qa.pop_front();
          chk(a_instr == e, "a_instr", int'(a_instr), int'(e));
        end
        ha = a_instr;
        if (a_instr == 10'h080) last_cs = -1;
        else if (a_instr == 10'h0CF) begin
          if (last_cs >= 0) chk(cyc - last_cs == 20, "a_blink_period", cyc - last_cs, 20);
          last_cs = cyc;
        end
      end else if (a_en && pa) begin
        chk(a_instr == ha, "a_instr_stable", int'(a_instr), int'(ha));
      end
      pa = a_en;
    end
  end

  initial begin
    logic pb;
    logic [9:0] hb, e;
    pb = 1'b0; hb = '0;
    forever begin
      @(negedge clk);
      if (b_en && !pb) begin
        chk(qb.size() > 0, "b_expected_pending", qb.size(), 1);
        if (qb.size() > 0) begin
          e = qb.pop_front();
          chk(b_instr == e, "b_instr", int'(b_instr), int'(e));
        end
        hb = b_instr;
      end else if (b_en && pb) begin
        chk(b_instr == hb, "b_instr_stable", int'(b_instr), int'(hb));
      end
      pb = b_en;
    end
  end

  initial begin
    reset = 1'b0; reset_b = 1'b0; init_done = 1'b0; refresh_req = 1'b0;
    blink_en = 1'b1; cursor_row = 2'd1; cursor_col = 6'd15;
    #1;
    chk(a_en == 0 && a_instr == 0 && a_addr == 0 && a_busy == 0, "a_reset_outputs",
        int'({a_en, a_busy, a_instr}), 0);
    chk(b_en == 0 && b_instr == 0 && b_addr == 0 && b_busy == 0, "b_reset_outputs",
        int'({b_en, b_busy, b_instr}), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1; reset_b = 1'b1;

    push_draw(1'b0, 2, 16);
    push(1'b0, 10'h0CF); push(1'b0, 10'h2FF); push(1'b0, 10'h0CF); push(1'b0, 10'h220);
    push_draw(1'b1, 4, 20);
    while (cyc < 10) @(posedge clk);
    #1 init_done = 1'b1;

    fork
      begin
        wait_busy(1'b0, 34, "a_busy_fall_after_34_done");
        wait_q(1'b0, 0, 300, "a_blink_on_off_drain");

        blink_en = 1'b0;
        push(1'b0, 10'h0CF); push(1'b0, 10'h241);
        wait_q(1'b0, 0, 100, "a_cursor_memchar_drain");

        push_draw(1'b0, 2, 16); push_draw(1'b0, 2, 16);
        push(1'b0, 10'h0CF); push(1'b0, 10'h241);
        pulse_refresh();
        wait_q(1'b0, 60, 400, "a_refresh_progress1");
        pulse_refresh();
        wait_q(1'b0, 50, 400, "a_refresh_progress2");
        pulse_refresh();
        wait_q(1'b0, 0, 1500, "a_one_extra_redraw_drain");

        push_draw(1'b0, 2, 16);
        pulse_refresh();
        wait_q(1'b0, 25, 400, "a_redraw3_progress");
        begin
          int n = 0;
          while (!(a_en && a_instr[9]) && n < 50) begin @(posedge clk); #1; n++; end
          chk(a_en && a_instr[9], "a_write_in_flight", int'({a_en, a_instr}), 1);
        end
        #2 reset = 1'b0; init_done = 1'b0;
        #1;
        chk(a_en == 0 && a_instr == 0 && a_addr == 0 && a_busy == 0, "a_async_reset_outputs",
            int'({a_en, a_busy, a_instr}), 0);
        qa.delete();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1; a_dones = 0;
        push_draw(1'b0, 2, 16);
        push(1'b0, 10'h0CF); push(1'b0, 10'h241);
        repeat (5) @(posedge clk);
        #1 init_done = 1'b1;
        wait_busy(1'b0, 34, "a_restart_busy_fall");
        wait_q(1'b0, 0, 100, "a_restart_cursor_drain");
      end
      begin
        wait_busy(1'b1, 84, "b_busy_fall_after_84_done");
        wait_q(1'b1, 0, 50, "b_draw_drain");
      end
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
